// File: rtl/uart_mem_loader.sv
// uart_mem_loader
// Serial command responder that gives a host single-word access to the unified
// 32-bit word memory through the shared data port while the core is held.
// Command frames arrive 8N1 on rx: 'W' addr d3 d2 d1 d0 writes a word and is
// answered with ACK (0x06); 'R' addr reads a word and is answered with its four
// bytes, MSB first. Unknown commands and out-of-range addresses get NAK (0x15).
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset (0 = reset)
//   rx            serial input, idle high
//   tx            serial output, idle high
//   mem_addr      word address presented to the memory data port
//   mem_read_en   read strobe, high for the single execute cycle of an 'R'
//   mem_read_val  read data, combinational from mem_addr
//   mem_write_en  write strobe, high for the single execute cycle of a 'W'
//   mem_write_val write data
//   busy          high while a command is in progress
//   frame_err     one-cycle pulse when a received stop bit is 0
module uart_mem_loader #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int MEM_SIZE     = 256,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  input  logic [31:0] mem_read_val,
  output logic        mem_write_en,
  output logic [31:0] mem_write_val,
  output logic        busy,
  output logic        frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CNT_W     = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] BYTE_ACK  = 8'h06;
  localparam logic [7:0] BYTE_NAK  = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, SEND} cmd_state_t;

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: rx_valid / frame_err pulse in the cycle after the stop-bit sample.
  rx_state_t            rx_state;
  logic [BIT_CNT_W-1:0] rx_cnt;
  logic [2:0]           rx_bit_idx;
  logic [7:0]           rx_data;
  logic                 rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Re-check mid start bit; a high line here was only a glitch.
          if (rx_cnt == BIT_CNT_W'(HALF_BIT - 1)) begin
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt  <= '0;
            rx_data <= {rx_sync, rx_data[7:1]};
            if (rx_bit_idx == 3'd7) rx_state <= RX_STOP;
            else rx_bit_idx <= rx_bit_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) rx_valid  <= 1'b1;
            else         frame_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Command FSM with the transmitter folded into SEND. NAKs also pass through
  // EXEC (without strobes) so that all response loading happens in one place.
  cmd_state_t           state;
  logic                 is_read;
  logic                 nak;
  logic [1:0]           byte_cnt;
  logic [TO_CNT_W-1:0]  to_cnt;
  logic [BIT_CNT_W-1:0] tx_cnt;
  logic [3:0]           tx_bit_idx;
  logic [8:0]           tx_shift;
  logic [23:0]          tx_buf;
  logic [1:0]           tx_left;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      is_read       <= 1'b0;
      nak           <= 1'b0;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      tx_cnt        <= '0;
      tx_bit_idx    <= '0;
      tx_shift      <= '1;
      tx_buf        <= '0;
      tx_left       <= '0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              state   <= ADDR;
              busy    <= 1'b1;
              is_read <= (rx_data == CMD_READ);
            end else begin
              nak   <= 1'b1;
              state <= EXEC;
            end
          end
        end
        ADDR: begin
          if (frame_err || to_cnt == TO_CNT_W'(TIMEOUT_CLKS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            to_cnt   <= '0;
            byte_cnt <= '0;
            mem_addr <= {24'h0, rx_data};
            if ({24'h0, rx_data} >= 32'(MEM_SIZE)) begin
              nak   <= 1'b1;
              state <= EXEC;
            end else if (is_read) begin
              nak         <= 1'b0;
              mem_read_en <= 1'b1;
              state       <= EXEC;
            end else begin
              state <= DATA;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA: begin
          if (frame_err || to_cnt == TO_CNT_W'(TIMEOUT_CLKS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            to_cnt        <= '0;
            mem_write_val <= {mem_write_val[23:0], rx_data};
            if (byte_cnt == 2'd3) begin
              nak          <= 1'b0;
              mem_write_en <= 1'b1;
              state        <= EXEC;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        EXEC: begin
          // The first start bit goes out on the edge that leaves EXEC.
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          busy         <= 1'b1;
          state        <= SEND;
          tx           <= 1'b0;
          tx_cnt       <= '0;
          tx_bit_idx   <= '0;
          if (nak) begin
            tx_shift <= {1'b1, BYTE_NAK};
            tx_left  <= 2'd0;
          end else if (is_read) begin
            tx_shift <= {1'b1, mem_read_val[31:24]};
            tx_buf   <= mem_read_val[23:0];
            tx_left  <= 2'd3;
          end else begin
            tx_shift <= {1'b1, BYTE_ACK};
            tx_left  <= 2'd0;
          end
        end
        SEND: begin
          // tx_bit_idx 0 is the start bit, 1..8 data, 9 the stop bit.
          if (tx_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_bit_idx == 4'd9) begin
              if (tx_left != 2'd0) begin
                tx         <= 1'b0;
                tx_shift   <= {1'b1, tx_buf[23:16]};
                tx_buf     <= {tx_buf[15:0], 8'h00};
                tx_left    <= tx_left - 1'b1;
                tx_bit_idx <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tx         <= tx_shift[0];
              tx_shift   <= {1'b1, tx_shift[8:1]};
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
